// File: rtl/stage_ex_mdu_pkg.sv
// Shared types and constants for the EX-stage multiply/divide unit.
// STAGE_EX_MDU_DIV_EN adds the DIV state and divider datapath.
package stage_ex_mdu_pkg;

  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1100;

  localparam int ITER_CNT = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef STAGE_EX_MDU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_MUL  = 2'd2,
    STEP_DIV  = 2'd3
  } step_t;

endpackage

// File: rtl/stage_ex_mdu_step.sv
// One-iteration shift-add multiply / restoring divide datapath.
// Divide step present only with STAGE_EX_MDU_DIV_EN.
import stage_ex_mdu_pkg::*;

module stage_ex_mdu_step (
  input  logic        clk,
  input  logic        rst_n,
  input  step_t       cmd,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef STAGE_EX_MDU_DIV_EN
  output logic [31:0] quot_nxt,
  output logic        div_zero,
`endif
  output logic [31:0] prod_nxt
);

  // acc: product accumulator / remainder
  // opa: multiplier / dividend-quotient
  // opb: multiplicand / divisor
  logic [31:0] acc, acc_n;
  logic [31:0] opa, opa_n;
  logic [31:0] opb, opb_n;

`ifdef STAGE_EX_MDU_DIV_EN
  logic [32:0] shifted;
  logic        fits;

  assign shifted = {acc, opa[31]};
  assign fits = shifted >= {1'b0, opb};
`endif

  always_comb begin
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    unique case (cmd)
      STEP_LOAD: begin
        acc_n = '0;
        opa_n = a;
        opb_n = b;
      end
      STEP_MUL: begin
        if (opa[0]) acc_n = acc + opb;
        opa_n = opa >> 1;
        opb_n = opb << 1;
      end
`ifdef STAGE_EX_MDU_DIV_EN
      STEP_DIV: begin
        // restore by keeping the shifted value when the trial fails
        acc_n = fits ? (shifted[31:0] - opb)
                     : shifted[31:0];
        opa_n = {opa[30:0], fits};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      opa <= '0;
      opb <= '0;
    end else begin
      acc <= acc_n;
      opa <= opa_n;
      opb <= opb_n;
    end
  end

  assign prod_nxt = acc_n;
`ifdef STAGE_EX_MDU_DIV_EN
  assign quot_nxt = opa_n;
  assign div_zero = (opb == '0);
`endif

endmodule

// File: rtl/stage_ex_mdu.sv
// EX-stage iterative MUL/DIV sequencer with pipeline stall.
// Define STAGE_EX_MDU_DIV_EN to build the divide path.
import stage_ex_mdu_pkg::*;

module stage_ex_mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t state, state_n;
  step_t cmd;
  logic [CNT_W-1:0] cnt;
  logic [31:0] res_q, res_n;
  logic ld_res;
  logic is_mul, is_div, acc_ok, last;
  logic [31:0] prod_nxt;

`ifdef STAGE_EX_MDU_DIV_EN
  logic [31:0] quot_nxt;
  logic div_zero;

  assign is_div = (op == OP_DIV);
`else
  assign is_div = 1'b0;
`endif

  assign is_mul = (op == OP_MUL);
  assign acc_ok = rst_n & start & ~flush
                & (is_mul | is_div);
  assign last = (cnt == LAST_CNT);

  stage_ex_mdu_step u_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd),
    .a        (a),
    .b        (b),
`ifdef STAGE_EX_MDU_DIV_EN
    .quot_nxt (quot_nxt),
    .div_zero (div_zero),
`endif
    .prod_nxt (prod_nxt)
  );

  always_comb begin
    state_n = state;
    cmd = STEP_HOLD;
    ld_res = 1'b0;
    res_n = res_q;
    unique case (state)
      S_IDLE: begin
        if (acc_ok) begin
          cmd = STEP_LOAD;
`ifdef STAGE_EX_MDU_DIV_EN
          state_n = is_div ? S_DIV : S_MUL;
`else
          state_n = S_MUL;
`endif
        end
      end
      S_MUL: begin
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          cmd = STEP_MUL;
          if (last) begin
            state_n = S_DONE;
            ld_res = 1'b1;
            res_n = prod_nxt;
          end
        end
      end
`ifdef STAGE_EX_MDU_DIV_EN
      S_DIV: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (div_zero) begin
          state_n = S_DONE;
          ld_res = 1'b1;
          res_n = '1;
        end else begin
          cmd = STEP_DIV;
          if (last) begin
            state_n = S_DONE;
            ld_res = 1'b1;
            res_n = quot_nxt;
          end
        end
      end
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      res_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && acc_ok)
        cnt <= '0;
      else if (busy)
        cnt <= cnt + 1'b1;
      if (ld_res)
        res_q <= res_n;
    end
  end

`ifdef STAGE_EX_MDU_DIV_EN
  assign busy = (state == S_MUL)
              | (state == S_DIV);
`else
  assign busy = (state == S_MUL);
`endif
  assign done = (state == S_DONE);
  assign stall = ((state == S_IDLE) & acc_ok) | busy;
  assign result = res_q;

endmodule

// File: tb/tb_stage_ex_mdu.sv
// Self-checking bench for stage_ex_mdu: cycle model plus directed cases.
// Follows STAGE_EX_MDU_DIV_EN to know whether DIV is accepted.
module tb_stage_ex_mdu;

  localparam bit DIV_EN =
`ifdef STAGE_EX_MDU_DIV_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [3:0] MUL = 4'b1000;
  localparam logic [3:0] DIV = 4'b1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic stall, busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  // model: mode 0 idle, 1 iterating, 2 result cycle
  int m_mode = 0;
  int m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res = '0;

  stage_ex_mdu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit vop(input logic [3:0] o);
    return (o == MUL) || (DIV_EN && o == DIV);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_left = 0;
    m_pend = '0;
    m_res = '0;
  endtask

  // per-cycle compare against the model
  initial begin
    logic exp_stall;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      exp_stall = (m_mode == 1) ||
                  (m_mode == 0 && rst_n && start &&
                   !flush && vop(op));
      chk("m_busy", busy, m_mode == 1);
      chk("m_done", done, m_mode == 2);
      chk("m_stall", stall, exp_stall);
      chk("m_result", result, m_res);
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        case (m_mode)
          0: if (start && !flush && vop(op)) begin
            if (op == DIV) begin
              m_pend = (b == 0) ? 32'hFFFF_FFFF : a / b;
              m_left = (b == 0) ? 1 : 32;
            end else begin
              m_pend = a * b;
              m_left = 32;
            end
            m_mode = 1;
          end
          1: if (flush) begin
            m_mode = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_mode = 2;
              m_res = m_pend;
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  // request in cycle N (entered just after an edge); k counts cycles from N
  task automatic op_run(input string nm,
                        input logic [3:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit hold,
                        input int fl_at,
                        input int exp_lat,
                        input int exp_stalls,
                        input logic [31:0] exp_res);
    int lat, nd, ns;
    lat = -1;
    nd = 0;
    ns = 0;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    flush = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (lat < 0) lat = k;
      end
      if (stall) ns++;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      a = $urandom;
      b = $urandom;
      flush = (k + 1 == fl_at);
    end
    start = 1'b0;
    flush = 1'b0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " pulses"}, nd, (exp_lat < 0) ? 0 : 1);
    chk({nm, " stalls"}, ns, exp_stalls);
    chk({nm, " result"}, result, exp_res);
    repeat (40) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    #1;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst stall", stall, 1'b0);
    chk("rst result", result, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    op_run("mul7x6", MUL, 7, 6, 0, -1, 33, 33, 42);
    op_run("div100_7", DIV, 100, 7, 0, -1,
           DIV_EN ? 33 : -1, DIV_EN ? 33 : 0,
           DIV_EN ? 32'd14 : 32'd42);
    op_run("divmax_1", DIV, 32'hFFFF_FFFF, 1, 0, -1,
           DIV_EN ? 33 : -1, DIV_EN ? 33 : 0,
           DIV_EN ? 32'hFFFF_FFFF : 32'd42);
    op_run("div5_0", DIV, 5, 0, 0, -1,
           DIV_EN ? 2 : -1, DIV_EN ? 2 : 0,
           DIV_EN ? 32'hFFFF_FFFF : 32'd42);
    prev = DIV_EN ? 32'hFFFF_FFFF : 32'd42;
    op_run("mul_flush", MUL, 3, 5, 0, 10, -1, 11, prev);
    op_run("op0", 4'b0000, 9, 9, 0, -1, -1, 0, prev);
    op_run("mul_hold", MUL, 9, 9, 1, -1, 33, 34, 81);

    // reset in the middle of an operation
    start = 1'b1;
    op = DIV_EN ? DIV : MUL;
    a = 1000;
    b = 3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst stall", stall, 1'b0);
    chk("midrst result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    op_run("mul2x2", MUL, 2, 2, 0, -1, 33, 33, 4);

    // random traffic, checked cycle by cycle by the model
    for (int i = 0; i < 2500; i++) begin
      start = ($urandom_range(3) == 0);
      case ($urandom_range(3))
        0: op = MUL;
        1: op = DIV;
        2: op = 4'b0000;
        default: op = 4'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(7) == 0) ? 32'h0 :
          ($urandom_range(1) == 0) ? 32'($urandom_range(255))
                                   : 32'($urandom);
      flush = ($urandom_range(31) == 0);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_ex_mdu.md
STAGE_EX_MDU -- requirements
Module: stage_ex_mdu

Interface
REQ-001 The module SHALL have one clock, and reset SHALL be asynchronous and active-low.
REQ-002 The port clk SHALL be an input, 1 bit wide, and SHALL be the rising-edge clock.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and SHALL be the asynchronous active-low reset.
REQ-004 The port start SHALL be an input, 1 bit wide, and SHALL request a new EX-stage operation.
REQ-005 The port op SHALL be an input, 4 bits wide, and SHALL carry the EX ALU opcode; MUL is 4'b1000 and DIV is 4'b1100.
REQ-006 The ports a and b SHALL be inputs, 32 bits wide each; for DIV, a is the dividend and b is the divisor.
REQ-007 The port flush SHALL be an input, 1 bit wide, and SHALL abort an operation in flight.
REQ-008 The port stall SHALL be an output, 1 bit wide, and SHALL hold the pipeline front end.
REQ-009 The port busy SHALL be an output, 1 bit wide, and SHALL be high in states MUL and DIV.
REQ-010 The port done SHALL be an output, 1 bit wide, and SHALL be a one-cycle result-valid pulse.
REQ-011 The port result SHALL be an output, 32 bits wide, and SHALL carry the product low word or the quotient.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, MUL, DIV and DONE.
REQ-013 An accept SHALL occur when the state is IDLE, start=1 and op is MUL or DIV; a and b SHALL be captured at that clock edge.
REQ-014 When start=1 in IDLE with any other op, the request SHALL be ignored, and stall SHALL remain 0.
REQ-015 A 6-bit iteration counter SHALL be cleared on accept and SHALL increment once per cycle in MUL and DIV.
REQ-016 MUL SHALL be unsigned shift-add over 32 iterations, and result SHALL be the low 32 bits of a*b.
REQ-017 DIV SHALL be unsigned restoring division over 32 iterations, and result SHALL be the quotient; the remainder SHALL be held internally and not output.
REQ-018 Latency: with accept at edge N, the iterations SHALL occupy cycles N+1..N+32, done SHALL be 1 in cycle N+33 (state DONE), and the FSM SHALL return to IDLE in cycle N+34.
REQ-019 DIV with b=0 SHALL skip the iterations, enter DONE one cycle after accept, and give result=32'hFFFF_FFFF.
REQ-020 stall SHALL equal (IDLE & accept-condition) | MUL | DIV; stall SHALL be 0 in DONE so that the stage advances with the result.
REQ-021 result SHALL be held stable from DONE until the next accept and SHALL NOT change during iterations.
REQ-022 start asserted while in MUL, DIV or DONE SHALL be ignored; back-to-back operation SHALL require the request to be presented again in IDLE.
REQ-023 flush=1 in MUL or DIV SHALL move the FSM to IDLE at the next edge with no done pulse, and result SHALL remain unchanged.
REQ-024 flush=1 in IDLE SHALL suppress acceptance in that cycle, even when start=1.
REQ-025 flush=1 in DONE SHALL NOT suppress done; the FSM SHALL go to IDLE as normal.
REQ-026 Counter wrap SHALL be unreachable; the counter SHALL saturate its use at 32 and exit on count==31.

Reset
REQ-027 Asserting rst_n low SHALL, at any time including mid-operation, force state=IDLE, counter=0, busy=0, done=0, stall=0, result=32'h0, and clear the internal operand and accumulator registers.
REQ-028 Following rst_n release, an accept SHALL be possible at the first rising edge.

Configuration
REQ-029 The macro STAGE_EX_MDU_DIV_EN SHALL control the divide feature.
REQ-030 With STAGE_EX_MDU_DIV_EN defined, the DIV state and the divider datapath SHALL be compiled in as specified.
REQ-031 Without STAGE_EX_MDU_DIV_EN, the DIV state and datapath SHALL be absent; DIV SHALL be treated as a non-accepted op (no stall, no done), and only MUL SHALL be sequenced.

Structure
REQ-032 A shared package SHALL hold the opcode constants OP_MUL=4'b1000 and OP_DIV=4'b1100, the state enum, and ITER_CNT=32.
REQ-033 The iterative datapath, comprising the shift-add and restore step, SHALL be one sub-module stage_ex_mdu_step, and the FSM and counter SHALL stay in stage_ex_mdu.

Verification
REQ-034 The bench SHALL cover: MUL a=7, b=6 accepted at edge N -> stall=1 in cycles N..N+32, done=1 in N+33 only, result=42.
REQ-035 The bench SHALL cover: DIV a=100, b=7 -> done in N+33, result=14; DIV a=32'hFFFF_FFFF, b=1 -> result=32'hFFFF_FFFF.
REQ-036 The bench SHALL cover: DIV a=5, b=0 -> done in N+2, result=32'hFFFF_FFFF.
REQ-037 The bench SHALL cover: MUL a=3, b=5 with flush at N+10 -> IDLE at N+11, no done pulse, result keeps its previous value.
REQ-038 The bench SHALL cover: rst_n low at N+15 of DIV -> all outputs 0 immediately; a new MUL 2x2 after release -> result=4.
REQ-039 The bench SHALL cover: start with op=4'b0000 in IDLE -> no state change and stall=0; start held high through a MUL -> exactly one done pulse.
